// File: rtl/stepdir_sched.sv
// Multi-axis stepdir scheduler: routes tagged move entries to per-channel queues,
// starts a channel set together at an absolute time, and detects completion/abort.
module stepdir_sched #(
  parameter int NUM_CHANNELS = 6,
  parameter int TIME_BITS    = 32,
  localparam int CH_BITS     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [71:0]             cmd_data,
  input  logic [CH_BITS-1:0]      cmd_chan,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    arm_en,
  input  logic [NUM_CHANNELS-1:0] arm_mask,
  input  logic [TIME_BITS-1:0]    arm_time,
  input  logic                    abort,
  input  logic                    clr_flags,
  input  logic [TIME_BITS-1:0]    systime,
  output logic [71:0]             ch_wr_data,
  output logic [NUM_CHANNELS-1:0] ch_wr_en,
  input  logic [NUM_CHANNELS-1:0] ch_queue_empty,
  input  logic [NUM_CHANNELS-1:0] ch_running,
  output logic [NUM_CHANNELS-1:0] ch_start,
  output logic [NUM_CHANNELS-1:0] ch_reset,
  output logic [1:0]              state,
  output logic                    done,
  output logic [NUM_CHANNELS-1:0] underrun,
  output logic                    bad_chan,
  output logic                    arm_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2, ABORT = 2'd3} state_t;

  localparam logic [CH_BITS:0] NCH_W = (CH_BITS+1)'(NUM_CHANNELS);

  state_t                  state_q, state_d;
  logic [NUM_CHANNELS-1:0] mask_q, mask_d;
  logic [TIME_BITS-1:0]    time_q, time_d;
  logic [1:0]              run_cnt_q, run_cnt_d;
  logic                    quiet_q, quiet_d;
  logic                    done_q, done_d;
  logic [71:0]             wr_data_q, wr_data_d;
  logic [NUM_CHANNELS-1:0] wr_en_q, wr_en_d;
  logic [NUM_CHANNELS-1:0] ur_q, ur_d, ur_set;
  logic                    bad_q, bad_d;
  logic                    aerr_q, aerr_d;

  logic                    accept, chan_ok, reached, all_quiet;
  logic [TIME_BITS-1:0]    tdiff;

  assign cmd_ready = (state_q != ABORT);
  assign accept    = cmd_valid && cmd_ready;
  assign chan_ok   = ({1'b0, cmd_chan} < NCH_W);
  // Modular difference keeps the start check correct across systime wrap.
  assign tdiff     = systime - time_q;
  assign reached   = ~tdiff[TIME_BITS-1];
  assign all_quiet = &(~mask_q | (~ch_running & ch_queue_empty));

  always_comb begin
    wr_en_d   = '0;
    wr_data_d = wr_data_q;
    if (accept) begin
      wr_data_d = cmd_data;
      if (chan_ok) wr_en_d = NUM_CHANNELS'(1) << cmd_chan;
    end
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    time_d    = time_q;
    run_cnt_d = run_cnt_q;
    quiet_d   = quiet_q;
    done_d    = 1'b0;
    ur_set    = '0;
    unique case (state_q)
      IDLE: if (arm_en && arm_mask != '0) begin
        state_d = ARMED;
        mask_d  = arm_mask;
        time_d  = arm_time;
      end
      ARMED: if (reached) begin
        state_d   = RUN;
        ur_set    = mask_q & ch_queue_empty;
        run_cnt_d = 2'd0;
        quiet_d   = 1'b0;
      end
      RUN: begin
        // Channels raise running one cycle after start; skip the first two cycles.
        if (run_cnt_q < 2'd2) begin
          run_cnt_d = run_cnt_q + 2'd1;
        end else if (all_quiet) begin
          if (quiet_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
          quiet_d = 1'b1;
        end else begin
          quiet_d = 1'b0;
        end
      end
      ABORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = ABORT;
      mask_d  = '0;
      time_d  = '0;
      quiet_d = 1'b0;
      done_d  = 1'b0;
      ur_set  = '0;
    end
  end

  // Sticky flags: a set in the same cycle as clr_flags wins.
  assign ur_d   = (ur_q & {NUM_CHANNELS{~clr_flags}}) | ur_set;
  assign bad_d  = (bad_q & ~clr_flags) | (accept && !chan_ok);
  assign aerr_d = (aerr_q & ~clr_flags) | (arm_en && (state_q != IDLE || arm_mask == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      time_q    <= '0;
      run_cnt_q <= 2'd0;
      quiet_q   <= 1'b0;
      done_q    <= 1'b0;
      wr_data_q <= '0;
      wr_en_q   <= '0;
      ur_q      <= '0;
      bad_q     <= 1'b0;
      aerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      time_q    <= time_d;
      run_cnt_q <= run_cnt_d;
      quiet_q   <= quiet_d;
      done_q    <= done_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      ur_q      <= ur_d;
      bad_q     <= bad_d;
      aerr_q    <= aerr_d;
    end
  end

  // A write staged in the cycle abort was seen is dropped while ABORT is shown.
  assign ch_wr_en   = (state_q == ABORT) ? '0 : wr_en_q;
  assign ch_wr_data = wr_data_q;
  assign ch_start   = (state_q == RUN) ? mask_q : '0;
  assign ch_reset   = (state_q == ABORT) ? '1 : '0;
  assign state      = state_q;
  assign done       = done_q;
  assign underrun   = ur_q;
  assign bad_chan   = bad_q;
  assign arm_err    = aerr_q;

endmodule
